// File: rtl/cook_timer.sv
// Cook-time down-counter for the microwave controller's heat/done handshake.
// It counts a loaded tick count down while Heat is high and raises done at zero.
module cook_timer #(
  parameter int TICK_DIV = 4,
  parameter int TIME_W   = 8,
  parameter int MAX_TIME = 200
) (
  input  logic              clk,
  input  logic              sys_reset,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic              Heat,
  input  logic              Error,
  output logic              done,
  output logic [TIME_W-1:0] remaining,
  output logic              running,
  output logic              sat
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [TIME_W-1:0] MAX_T    = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    PAUSE,
    FINISH
  } state_t;

  state_t            state, state_next;
  logic [PRE_W-1:0]  prescaler, prescaler_next;
  logic [TIME_W-1:0] remaining_next;
  logic              sat_next;
  logic              load_ok;

  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t);
    return (t > MAX_T) ? MAX_T : t;
  endfunction

  function automatic logic is_clamped(input logic [TIME_W-1:0] t);
    return (t > MAX_T);
  endfunction

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    remaining_next = remaining;
    sat_next       = sat;
    load_ok        = load && (time_in != '0);

    if (Error) begin
      state_next     = IDLE;
      prescaler_next = '0;
      remaining_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_ok) begin
            state_next     = ARMED;
            remaining_next = clamp_time(time_in);
            sat_next       = is_clamped(time_in);
          end
        end
        ARMED: begin
          if (load_ok) begin
            remaining_next = clamp_time(time_in);
            sat_next       = is_clamped(time_in);
          end
          if (Heat) begin
            state_next     = RUN;
            prescaler_next = '0;
          end
        end
        RUN: begin
          // A Heat drop on the terminal prescaler cycle pauses without ticking.
          if (!Heat) begin
            state_next = PAUSE;
          end else if (prescaler == PRE_LAST) begin
            prescaler_next = '0;
            if (remaining != '0) begin
              remaining_next = remaining - TIME_ONE;
              if (remaining == TIME_ONE) state_next = FINISH;
            end
          end else begin
            prescaler_next = prescaler + PRE_ONE;
          end
        end
        PAUSE: begin
          if (load_ok) begin
            remaining_next = clamp_time(time_in);
            sat_next       = is_clamped(time_in);
          end
          if (Heat) state_next = RUN;
        end
        FINISH: begin
          remaining_next = '0;
          if (!Heat) state_next = IDLE;
        end
        default: begin
          state_next     = IDLE;
          prescaler_next = '0;
          remaining_next = '0;
        end
      endcase
    end
  end

  // done/running are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      sat       <= 1'b0;
      done      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      remaining <= remaining_next;
      sat       <= sat_next;
      done      <= (state_next == FINISH);
      running   <= (state_next == RUN);
    end
  end

endmodule
